// File: rtl/cmn_pipe_reg.sv
// cmn_pipe_reg: multi-stage val/rdy pipeline register with bubble collapsing,
// back-pressure, synchronous flush and a registered occupancy count.

module cmn_pipe_reg_chk #(
  parameter int p_nbits = 32,
  parameter int p_depth = 2
) (
  input logic                         clk,
  input logic                         reset,
  input logic                         flush,
  input logic                         istream_rdy,
  input logic                         ostream_val,
  input logic                         ostream_rdy,
  input logic [p_nbits-1:0]           ostream_msg,
  input logic [$clog2(p_depth+1)-1:0] occupancy,
  input logic [p_depth-1:0]           val
);

  a_occ_range: assert property (@(posedge clk) disable iff (reset)
    int'(occupancy) <= p_depth);

  a_occ_count: assert property (@(posedge clk) disable iff (reset)
    int'(occupancy) == $countones(val));

  a_flush_blocks_input: assert property (@(posedge clk) disable iff (reset)
    !(flush && istream_rdy));

  // A stalled output item must stay put until it is taken.
  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (ostream_val && !ostream_rdy && !flush) |=> (ostream_val && $stable(ostream_msg)));

endmodule

module cmn_pipe_reg #(
  parameter int                 p_nbits       = 32,
  parameter int                 p_depth       = 2,
  parameter logic [p_nbits-1:0] p_reset_value = {p_nbits{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         istream_val,
  output logic                         istream_rdy,
  input  logic [p_nbits-1:0]           istream_msg,
  output logic                         ostream_val,
  input  logic                         ostream_rdy,
  output logic [p_nbits-1:0]           ostream_msg,
  output logic [$clog2(p_depth+1)-1:0] occupancy
);

  localparam int c_occ_w = $clog2(p_depth + 1);

  if (p_depth < 1) begin : g_bad_depth
    $error("cmn_pipe_reg: p_depth must be at least 1");
  end
  if (p_nbits < 1) begin : g_bad_nbits
    $error("cmn_pipe_reg: p_nbits must be at least 1");
  end

  function automatic logic [c_occ_w-1:0] count_valid(input logic [p_depth-1:0] vals);
    logic [c_occ_w-1:0] cnt;
    cnt = {c_occ_w{1'b0}};
    for (int i = 0; i < p_depth; i++) begin
      cnt = cnt + c_occ_w'(vals[i]);
    end
    return cnt;
  endfunction

  logic [p_depth-1:0] val_r;
  logic [p_nbits-1:0] msg_r [p_depth];
  logic [c_occ_w-1:0] occ_r;

  logic [p_depth-1:0] rdy_s;
  logic [p_depth:0]   src_val_s;
  logic [p_nbits-1:0] src_msg_s [p_depth+1];
  logic [p_depth-1:0] val_nxt_s;

  // Ready chain: stage i may load if any stage from i to the output is empty
  // or the output is being taken, which is what lets bubbles collapse.
  always_comb begin
    logic tail_full_v;
    tail_full_v = 1'b1;
    rdy_s       = {p_depth{1'b0}};
    for (int i = p_depth - 1; i >= 0; i--) begin
      tail_full_v = tail_full_v & val_r[i];
      rdy_s[i]    = ostream_rdy | ~tail_full_v;
    end
  end

  // Source of each stage (index 0 is the upstream port) and next valid bits.
  always_comb begin
    src_val_s    = {val_r, istream_val};
    src_msg_s[0] = istream_msg;
    for (int i = 0; i < p_depth; i++) begin
      src_msg_s[i+1] = msg_r[i];
    end
    val_nxt_s = val_r;
    for (int i = 0; i < p_depth; i++) begin
      if (rdy_s[i]) begin
        val_nxt_s[i] = src_val_s[i];
      end else begin
        val_nxt_s[i] = val_r[i];
      end
    end
  end

  // Stage registers; reset and flush both clear every stage to the reset value.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      val_r <= {p_depth{1'b0}};
      occ_r <= {c_occ_w{1'b0}};
      for (int i = 0; i < p_depth; i++) begin
        msg_r[i] <= p_reset_value;
      end
    end else begin
      val_r <= val_nxt_s;
      occ_r <= count_valid(val_nxt_s);
      for (int i = 0; i < p_depth; i++) begin
        if (rdy_s[i] && src_val_s[i]) begin
          msg_r[i] <= src_msg_s[i];
        end
      end
    end
  end

  assign istream_rdy = rdy_s[0] & ~flush & ~reset;
  assign ostream_val = val_r[p_depth-1];
  assign ostream_msg = msg_r[p_depth-1];
  assign occupancy   = occ_r;

  cmn_pipe_reg_chk #(
    .p_nbits (p_nbits),
    .p_depth (p_depth)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .istream_rdy (istream_rdy),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg),
    .occupancy   (occupancy),
    .val         (val_r)
  );

endmodule
